// File: rtl/sram_to_sram_like_bridge.sv
// Converts the core's blocking SRAM-style access into one SRAM-like req/addr_ok/data_ok transaction.
// WRITE_EN=1 gives the data port; WRITE_EN=0 gives the read-only instruction port.
module sram_to_sram_like_bridge #(
  parameter int ADDR_W   = 32,
  parameter bit WRITE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sram_en,
  input  logic [3:0]        sram_wen,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic [31:0]       sram_wdata,
  output logic [31:0]       sram_rdata,
  output logic              stall,
  input  logic              longest_stall,
  input  logic              flush,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [31:0]       rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_cancel, w_cancel_nxt;
  logic [31:0]       r_buf;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_wr;
  logic [1:0]        r_size;

  logic              w_wr;
  logic [1:0]        w_size;
  logic [1:0]        w_off;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic              w_launch;
  logic              w_done_ok;
  logic              w_in_idle;
  logic              w_load_buf;

  // Write size and low address bits come from the byte-enable pattern; odd patterns write a full word.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    w_wr   = WRITE_EN && (sram_wen != 4'b0000);
    w_size = 2'd2;
    w_off  = 2'd0;
    if (w_wr) begin
      case (sram_wen)
        4'b0001: begin w_size = 2'd0; w_off = 2'd0; end
        4'b0010: begin w_size = 2'd0; w_off = 2'd1; end
        4'b0100: begin w_size = 2'd0; w_off = 2'd2; end
        4'b1000: begin w_size = 2'd0; w_off = 2'd3; end
        4'b0011: begin w_size = 2'd1; w_off = 2'd0; end
        4'b1100: begin w_size = 2'd1; w_off = 2'd2; end
        default: ;
      endcase
    end
    w_addr  = {sram_addr[ADDR_W-1:2], w_off};
    w_wdata = WRITE_EN ? sram_wdata : 32'h0;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cancel_nxt = r_cancel;
    w_launch     = 1'b0;
    w_done_ok    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_launch = sram_en & ~flush;
        if (w_launch) begin
          if (addr_ok && data_ok) begin
            w_state_nxt = S_DONE;
            w_done_ok   = 1'b1;
          end else if (addr_ok) begin
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A raised req cannot be withdrawn; a flush only marks the response for discard.
        if (flush) w_cancel_nxt = 1'b1;
        if (addr_ok) begin
          if (!data_ok) begin
            w_state_nxt = S_WAIT;
          end else if (flush || r_cancel) begin
            w_state_nxt  = S_IDLE;
            w_cancel_nxt = 1'b0;
          end else begin
            w_state_nxt = S_DONE;
            w_done_ok   = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (data_ok) begin
          if (flush || r_cancel) begin
            w_state_nxt  = S_IDLE;
            w_cancel_nxt = 1'b0;
          end else begin
            w_state_nxt = S_DONE;
            w_done_ok   = 1'b1;
          end
        end else if (flush) begin
          w_cancel_nxt = 1'b1;
        end
      end
      S_DONE: begin
        if (flush || !longest_stall) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_in_idle  = (r_state == S_IDLE);
  assign w_load_buf = w_done_ok & ~(w_in_idle ? w_wr : r_wr);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cancel <= 1'b0;
      r_buf    <= 32'h0;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_wr     <= 1'b0;
      r_size   <= 2'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cancel <= w_cancel_nxt;
      if (w_launch) begin
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
        r_wr    <= w_wr;
        r_size  <= w_size;
      end
      if (w_load_buf) r_buf <= rdata;
    end
  end

  // In IDLE the request is presented straight from the core inputs; afterwards from the captured copy.
  assign req        = rst & (w_in_idle ? (sram_en & ~flush) : (r_state == S_REQ));
  assign wr         = rst & (w_in_idle ? w_wr : r_wr);
  assign size       = w_in_idle ? w_size  : r_size;
  assign addr       = w_in_idle ? w_addr  : r_addr;
  assign wdata      = w_in_idle ? w_wdata : r_wdata;
  assign stall      = rst & sram_en & (r_state != S_DONE) & ~flush & ~r_cancel;
  assign sram_rdata = r_buf;

endmodule

// File: tb/tb_sram_to_sram_like_bridge.sv
// Directed bench for sram_to_sram_like_bridge: a stimulus process plays the core and the
// SRAM-like slave, a monitor process compares requests and results against scoreboard queues.
`timescale 1ns/1ps
module tb_sram_to_sram_like_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        longest_stall;
  logic        flush;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  logic [31:0] sram_rdata, i_sram_rdata;
  logic        stall, i_stall;
  logic        req, i_req;
  logic        wr, i_wr;
  logic [1:0]  size, i_size;
  logic [31:0] addr, i_addr;
  logic [31:0] wdata, i_wdata;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_req_q[$];
  logic [31:0] exp_res_q[$];
  logic [31:0] m_buf = 32'h0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          step = 0;

  always #5 clk = ~clk;

  sram_to_sram_like_bridge #(.ADDR_W(32), .WRITE_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .stall(stall),
    .longest_stall(longest_stall), .flush(flush), .req(req), .wr(wr), .size(size),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  sram_to_sram_like_bridge #(.ADDR_W(32), .WRITE_EN(1'b0)) u_dut_i (
    .clk(clk), .rst(rst), .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(i_sram_rdata), .stall(i_stall),
    .longest_stall(longest_stall), .flush(flush), .req(i_req), .wr(i_wr), .size(i_size),
    .addr(i_addr), .wdata(i_wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (step %0d): got 0x%08h, want 0x%08h", name, step, act, exp);
    end
  endtask

  // One complete access: addr_ok aok cycles after launch, data_ok dok cycles after addr_ok,
  // then hold cycles of longest_stall in DONE before release.
  task automatic run(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd,
                     input int aok, input int dok, input logic [31:0] rd, input int hold,
                     input logic e_wr, input logic [1:0] e_size, input logic [31:0] e_addr);
    int          n_stall;
    int          n_req;
    int          last;
    logic [31:0] exp_buf;
    step++;
    last    = aok + dok;
    exp_buf = (wen == 4'b0000) ? rd : m_buf;
    exp_req_q.push_back('{wr: e_wr, size: e_size, addr: e_addr, wdata: wd});
    exp_res_q.push_back(exp_buf);
    n_stall = 0;
    n_req   = 0;
    for (int c = 0; c <= last; c++) begin
      @(posedge clk); #1;
      sram_en       = 1'b1;
      sram_wen      = wen;
      sram_addr     = a;
      sram_wdata    = wd;
      flush         = 1'b0;
      longest_stall = 1'b0;
      addr_ok       = (c == aok);
      data_ok       = (c == last);
      rdata         = (c == last) ? rd : 32'hFFFF_0000;
      @(negedge clk);
      if (stall) n_stall++;
      if (req) n_req++;
      if (c == 0) begin
        check("iport_req", i_req, 1'b1);
        check("iport_wr", i_wr, 1'b0);
        check("iport_size", i_size, 2'd2);
        check("iport_wdata", i_wdata, 32'h0);
        check("iport_addr", i_addr, {a[31:2], 2'b00});
      end
    end
    for (int h = 0; h <= hold; h++) begin
      @(posedge clk); #1;
      addr_ok       = 1'b0;
      data_ok       = 1'b0;
      rdata         = 32'h0;
      longest_stall = (h < hold);
      @(negedge clk);
      check("done_stall", stall, 1'b0);
      check("done_req", req, 1'b0);
      check("done_rdata", sram_rdata, exp_buf);
    end
    check("stall_cycles", n_stall, last + 1);
    check("req_cycles", n_req, aok + 1);
    m_buf = exp_buf;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      sram_en = 1'b0; sram_wen = 4'b0; addr_ok = 1'b0; data_ok = 1'b0;
      longest_stall = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("idle_req", req, 1'b0);
      check("idle_stall", stall, 1'b0);
    end
  endtask

  // Monitor: every presented request must match the queue head; every result handed
  // back to the core (stall falling under a held sram_en) must match the result queue.
  initial begin : monitor
    logic prev_stall_en;
    prev_stall_en = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && req) begin
        if (exp_req_q.size() == 0) begin
          check("spurious_req", req, 1'b0);
        end else begin
          check("req_wr", wr, exp_req_q[0].wr);
          check("req_size", size, exp_req_q[0].size);
          check("req_addr", addr, exp_req_q[0].addr);
          check("req_wdata", wdata, exp_req_q[0].wdata);
          if (addr_ok) void'(exp_req_q.pop_front());
        end
      end
      if (rst && sram_en && !stall && !flush && prev_stall_en) begin
        if (exp_res_q.size() == 0) check("spurious_result", stall, 1'b1);
        else check("result", sram_rdata, exp_res_q.pop_front());
      end
      prev_stall_en = rst && sram_en && stall;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not reach its end within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1; sram_en = 1'b1; sram_wen = 4'hF; sram_addr = 32'h0000_0400;
    sram_wdata = 32'h1122_3344; longest_stall = 1'b0; flush = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_req", req, 1'b0);
    check("rst_wr", wr, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_rdata", sram_rdata, 32'h0);
    check("rst_istall", i_stall, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; sram_en = 1'b0; sram_wen = 4'b0;
    @(negedge clk);
    check("post_rst_req", req, 1'b0);

    run(4'b0000, 32'h1FC0_0004, 32'h0,         0, 1, 32'hDEAD_BEEF, 0, 1'b0, 2'd2, 32'h1FC0_0004);
    run(4'b1100, 32'h8000_0010, 32'hAABB_0000, 3, 1, 32'h0,         0, 1'b1, 2'd1, 32'h8000_0012);
    idle(1);
    run(4'b0000, 32'h0040_0007, 32'h0,         0, 1, 32'hCAFE_F00D, 4, 1'b0, 2'd2, 32'h0040_0004);
    run(4'b0000, 32'h0000_0020, 32'h0,         1, 0, 32'h0102_0304, 0, 1'b0, 2'd2, 32'h0000_0020);
    run(4'b0001, 32'h0000_0100, 32'h0000_00AA, 0, 0, 32'h0,         0, 1'b1, 2'd0, 32'h0000_0100);
    run(4'b0010, 32'h0000_0104, 32'h0000_BB00, 0, 0, 32'h0,         0, 1'b1, 2'd0, 32'h0000_0105);
    run(4'b0100, 32'h0000_0108, 32'h00CC_0000, 0, 0, 32'h0,         0, 1'b1, 2'd0, 32'h0000_010A);
    run(4'b1000, 32'h0000_010C, 32'hDD00_0000, 0, 0, 32'h0,         0, 1'b1, 2'd0, 32'h0000_010F);
    run(4'b0011, 32'h0000_0110, 32'h0000_EEFF, 0, 1, 32'h0,         0, 1'b1, 2'd1, 32'h0000_0110);
    run(4'b1111, 32'h0000_0114, 32'h1234_5678, 1, 1, 32'h0,         0, 1'b1, 2'd2, 32'h0000_0114);
    run(4'b0101, 32'h0000_0118, 32'h00EE_00FF, 0, 0, 32'h0,         0, 1'b1, 2'd2, 32'h0000_0118);
    run(4'b0110, 32'h0000_011B, 32'h00AB_CD00, 0, 0, 32'h0,         0, 1'b1, 2'd2, 32'h0000_0118);

    // Flush while req waits for addr_ok: req stays up, stall drops, response is discarded.
    step++;
    exp_req_q.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h0000_0200, wdata: 32'h0});
    @(posedge clk); #1;
    sram_en = 1'b1; sram_wen = 4'b0; sram_addr = 32'h0000_0200; sram_wdata = 32'h0;
    addr_ok = 1'b0; data_ok = 1'b0; longest_stall = 1'b0;
    @(negedge clk);
    check("fl_launch_req", req, 1'b1);
    check("fl_launch_stall", stall, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      sram_addr = 32'h0000_0300;
      flush     = (c == 1);
      addr_ok   = (c == 3);
      data_ok   = (c == 4);
      rdata     = (c == 4) ? 32'h1234_5678 : 32'h0;
      @(negedge clk);
      check("fl_req", req, (c <= 3) ? 1'b1 : 1'b0);
      check("fl_stall", stall, 1'b0);
    end
    @(posedge clk); #1;
    sram_en = 1'b0; data_ok = 1'b0; rdata = 32'h0; sram_addr = 32'h0;
    @(negedge clk);
    check("fl_end_req", req, 1'b0);
    check("fl_buf_kept", sram_rdata, m_buf);

    run(4'b0000, 32'h0000_0048, 32'h0,         0, 2, 32'h5A5A_5A5A, 1, 1'b0, 2'd2, 32'h0000_0048);

    // Reset pulse while waiting for data_ok.
    step++;
    exp_req_q.push_back('{wr: 1'b1, size: 2'd2, addr: 32'h0000_0400, wdata: 32'h1122_3344});
    @(posedge clk); #1;
    sram_en = 1'b1; sram_wen = 4'hF; sram_addr = 32'h0000_0400; sram_wdata = 32'h1122_3344;
    addr_ok = 1'b1; data_ok = 1'b0;
    @(negedge clk);
    check("rw_launch_stall", stall, 1'b1);
    @(posedge clk); #1;
    addr_ok = 1'b0;
    @(negedge clk);
    check("rw_wait_stall", stall, 1'b1);
    check("rw_wait_req", req, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("rw_rst_req", req, 1'b0);
    check("rw_rst_stall", stall, 1'b0);
    check("rw_rst_wr", wr, 1'b0);
    check("rw_rst_buf", sram_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1; sram_en = 1'b0; sram_wen = 4'b0;
    m_buf = 32'h0;
    @(negedge clk);
    check("rw_after_req", req, 1'b0);
    check("rw_after_buf", sram_rdata, 32'h0);

    run(4'b0000, 32'h0000_0060, 32'h0,         2, 2, 32'hA5A5_A5A5, 0, 1'b0, 2'd2, 32'h0000_0060);
    idle(2);

    check("req_queue_drained", exp_req_q.size(), 0);
    check("res_queue_drained", exp_res_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_to_sram_like_bridge.md
Name: sram_to_sram_like_bridge

Overview:
- Parametrised successor to the separate instruction-side and data-side SRAM-to-SRAM-like bridges; one module serves both ports, selected by WRITE_EN.
- Converts the core's blocking SRAM-style access (en/wen/addr/wdata, rdata next to stall) into one SRAM-like transaction (req/addr_ok, then data_ok).
- Adds three things the previous bridges lack: write-size/address derivation from byte enables, a flush that cancels an in-flight access, and a result buffer held until the pipeline-wide longest_stall releases.
- Sits between the mips core and the SRAM-like-to-AXI converter.

Parameters:
ADDR_W, 32, address width on both sides.
WRITE_EN, 1, 1 = data port (writes allowed); 0 = instruction port (wr tied 0, sram_wen ignored).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous reset, active-low.
sram_en  in  1  core requests an access this cycle.
sram_wen  in  4  byte write enables; all zero = read.
sram_addr  in  ADDR_W  byte address.
sram_wdata  in  32  write data, byte-lane aligned.
sram_rdata  out  32  read result (buffer register).
stall  out  1  core must hold the current access.
longest_stall  in  1  global pipeline stall; result is held while high.
flush  in  1  cancel the current access (exception/branch flush).
req  out  1  SRAM-like request.
wr  out  1  write flag.
size  out  2  0 = byte, 1 = half, 2 = word.
addr  out  ADDR_W  SRAM-like address.
wdata  out  32  SRAM-like write data.
addr_ok  in  1  request accepted.
data_ok  in  1  response/write completion.
rdata  in  32  SRAM-like read data.

Behaviour:
- States: IDLE, REQ (req held, awaiting addr_ok), WAIT (awaiting data_ok), DONE (result valid, awaiting longest_stall low).
- Flag cancel_q marks a transaction whose response is discarded.
- Reset (rst low, async): state IDLE, cancel_q 0, rdata buffer 0, addr_q/wdata_q/wr_q/size_q 0. While rst is low, req, wr and stall are forced 0.
- IDLE:
  - req = sram_en & ~flush, driven combinationally from the sram_* inputs.
  - Fields are captured into *_q on launch.
  - If addr_ok & data_ok -> DONE with capture; if addr_ok only -> WAIT; otherwise -> REQ.
- REQ:
  - req = 1; outputs come from *_q and are stable until addr_ok.
  - addr_ok -> WAIT; addr_ok & data_ok in the same cycle -> DONE.
- WAIT:
  - req = 0.
  - data_ok -> buffer <= rdata (reads only; writes leave the buffer unchanged) -> DONE.
- DONE: if ~longest_stall -> IDLE. A new request can launch in the next cycle (one idle cycle minimum between accesses).
- stall = sram_en & (state != DONE) & ~cancel_q-path; stall is 0 in DONE.
- Minimum latency with addr_ok in the launch cycle and data_ok one cycle later: stall high for 2 cycles.
- wr = WRITE_EN & |sram_wen.
- Reads: size = 2, addr = {sram_addr[ADDR_W-1:2], 2'b00}.
- Writes, size and addr[1:0] from wen:
  - 0001/0010/0100/1000 -> size 0, addr[1:0] = 0/1/2/3.
  - 0011/1100 -> size 1, addr[1:0] = 0/2.
  - 1111 -> size 2, addr[1:0] = 0.
  - Any other nonzero pattern -> size 2, aligned, full-word write.
- wdata passes through unchanged; in WRITE_EN=0 mode wdata = 0.
- Flush:
  - IDLE: suppresses the launch.
  - REQ: req cannot be withdrawn; set cancel_q, keep req until addr_ok, then go to WAIT.
  - WAIT with cancel_q: data_ok -> IDLE without buffer update; stall = 0 while cancelled.
  - DONE: -> IDLE.
  - flush in the same cycle as data_ok: response discarded.
- data_ok arriving in IDLE or REQ without a matching addr_ok is ignored (protocol violation, not expected).
- sram_en dropping mid-transaction (other than by flush) completes the transaction normally and the result is discarded at DONE.
- Reset mid-transaction returns to IDLE immediately; the downstream converter is reset by the same rst.

Test Plan:
- Read, addr 0x1FC00004, addr_ok in the launch cycle, data_ok next cycle with 0xDEADBEEF -> req high 1 cycle, stall high 2 cycles, sram_rdata = 0xDEADBEEF in DONE.
- Write, wen=1100, addr 0x80000010, wdata 0xAABB0000 -> wr=1, size=1, addr=0x80000012; addr_ok delayed 3 cycles keeps req/addr stable throughout.
- longest_stall held 4 cycles after data_ok -> stays in DONE with stall=0 and sram_rdata stable; no new req until 1 cycle after release.
- flush in REQ before addr_ok -> req held until addr_ok, stall drops, data_ok 0x12345678 not written into the buffer, back to IDLE.
- WRITE_EN=0 instance with wen=1111 -> wr=0, size=2, wdata=0.
- rst pulsed low while in WAIT -> req/stall 0 immediately, state IDLE, buffer 0.
